// File: rtl/final_layer_scheduler_if.sv
// Weight-memory read bus between the output-layer scheduler (master) and a
// synchronous weight memory (slave). Read data returns one cycle after the strobe.
interface final_layer_scheduler_if #(
   parameter int CHUNK  = 28,
   parameter int ADDR_W = 7
);
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_addr;
   logic [CHUNK-1:0]  w_data;

   modport master (output w_rd_en, output w_addr, input  w_data);
   modport slave  (input  w_rd_en, input  w_addr, output w_data);
endinterface

// File: rtl/final_layer_scheduler.sv
// Output-layer (10-neuron) sequencer for the BNN. Streams each neuron's weights
// CHUNK bits per cycle from an external synchronous memory, accumulates the
// XNOR-popcount score per neuron, tracks the running argmax and presents the
// winning class with layer_3_done while the top level stays in s_LAYER_3.
module final_layer_scheduler #(
   parameter int NUM_INPUTS  = 196,
   parameter int NUM_NEURONS = 10,
   parameter int CHUNK       = 28,
   parameter int ADDR_W      = 7
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [2:0]             state,
   input  logic [NUM_INPUTS-1:0]  data_in,
   final_layer_scheduler_if.master wmem,
   output logic [3:0]             answer,
   output logic [7:0]             best_score,
   output logic                   layer_3_done,
   output logic                   busy
);

   localparam int CHUNKS = NUM_INPUTS / CHUNK;
   localparam int TOTAL  = NUM_NEURONS * CHUNKS;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int NW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int SW     = $clog2(CHUNK + 1);

   localparam logic [2:0] S_LAYER_3 = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fsm_t;

   // Number of set bits in one CHUNK-wide word (0..CHUNK).
   function automatic logic [SW-1:0] f_popcount(input logic [CHUNK-1:0] v);
      logic [SW-1:0] cnt;
      cnt = {SW{1'b0}};
      for (int i = 0; i < CHUNK; i++) begin
         cnt = cnt + SW'(v[i]);
      end
      return cnt;
   endfunction

   fsm_t              r_fsm;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_addr;
   logic [NW-1:0]     r_n;
   logic [CW-1:0]     r_c;
   logic              r_busy;
   logic              r_done;

   logic              r_v_d;
   logic [NW-1:0]     r_n_d;
   logic [CW-1:0]     r_c_d;
   logic [7:0]        r_acc;
   logic [7:0]        r_best;
   logic [3:0]        r_answer;

   logic              w_active;
   logic              w_last_issue;
   logic              w_last_chunk;
   logic [CHUNK-1:0]  w_chunk;
   logic [SW-1:0]     w_pop;
   logic [7:0]        w_score;
   logic              w_consume;

   assign w_active     = (state == S_LAYER_3);
   assign w_last_issue = (r_addr == ADDR_W'(TOTAL - 1));
   assign w_last_chunk = (r_c == CW'(CHUNKS - 1));
   assign w_chunk      = data_in[int'(r_c_d) * CHUNK +: CHUNK];
   assign w_pop        = f_popcount(~(wmem.w_data ^ w_chunk));
   assign w_score      = r_acc + 8'(w_pop);
   // Read data counts only while the pass is still live; an abort edge drops it.
   assign w_consume    = r_v_d && w_active && ((r_fsm == ST_RUN) || (r_fsm == ST_DRAIN));

   assign wmem.w_rd_en = r_rd_en;
   assign wmem.w_addr  = r_addr;
   assign answer       = r_answer;
   assign best_score   = r_best;
   assign layer_3_done = r_done;
   assign busy         = r_busy;

   // Sequencer: phase FSM, read strobe/address and the neuron/chunk counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fsm   <= ST_IDLE;
         r_rd_en <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
         r_n     <= {NW{1'b0}};
         r_c     <= {CW{1'b0}};
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (w_active) begin
                  r_fsm   <= ST_RUN;
                  r_rd_en <= 1'b1;
                  r_addr  <= {ADDR_W{1'b0}};
                  r_n     <= {NW{1'b0}};
                  r_c     <= {CW{1'b0}};
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end else begin
                  r_fsm   <= ST_IDLE;
                  r_rd_en <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!w_active) begin
                  r_fsm   <= ST_IDLE;
                  r_rd_en <= 1'b0;
                  r_addr  <= {ADDR_W{1'b0}};
                  r_n     <= {NW{1'b0}};
                  r_c     <= {CW{1'b0}};
                  r_busy  <= 1'b0;
               end else if (w_last_issue) begin
                  // Final address is on the bus this cycle; stop reading.
                  r_fsm   <= ST_DRAIN;
                  r_rd_en <= 1'b0;
                  r_addr  <= {ADDR_W{1'b0}};
                  r_n     <= {NW{1'b0}};
                  r_c     <= {CW{1'b0}};
               end else begin
                  r_addr <= r_addr + ADDR_W'(1);
                  if (w_last_chunk) begin
                     r_c <= {CW{1'b0}};
                     r_n <= r_n + NW'(1);
                  end else begin
                     r_c <= r_c + CW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               r_busy <= 1'b0;
               if (!w_active) begin
                  r_fsm <= ST_IDLE;
               end else begin
                  r_fsm  <= ST_DONE;
                  r_done <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!w_active) begin
                  r_fsm  <= ST_IDLE;
                  r_done <= 1'b0;
               end else begin
                  r_fsm  <= ST_DONE;
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_fsm   <= ST_IDLE;
               r_rd_en <= 1'b0;
               r_addr  <= {ADDR_W{1'b0}};
               r_n     <= {NW{1'b0}};
               r_c     <= {CW{1'b0}};
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: qualify returning words, accumulate per-neuron score, keep argmax.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_v_d    <= 1'b0;
         r_n_d    <= {NW{1'b0}};
         r_c_d    <= {CW{1'b0}};
         r_acc    <= 8'd0;
         r_best   <= 8'd0;
         r_answer <= 4'd0;
      end else begin
         r_v_d <= r_rd_en && w_active;
         r_n_d <= r_n;
         r_c_d <= r_c;
         if ((r_fsm == ST_IDLE) && w_active) begin
            r_acc    <= 8'd0;
            r_best   <= 8'd0;
            r_answer <= 4'd0;
         end else if (w_consume) begin
            if (r_c_d == CW'(CHUNKS - 1)) begin
               r_acc <= 8'd0;
               // Strict compare: ties keep the lower neuron index.
               if ((r_n_d == {NW{1'b0}}) || (w_score > r_best)) begin
                  r_best   <= w_score;
                  r_answer <= 4'(r_n_d);
               end else begin
                  r_best   <= r_best;
                  r_answer <= r_answer;
               end
            end else begin
               r_acc <= w_score;
            end
         end else begin
            r_acc    <= r_acc;
            r_best   <= r_best;
            r_answer <= r_answer;
         end
      end
   end

endmodule

// File: doc/final_layer_scheduler.md
Name: final_layer_scheduler

Overview:
- Time-multiplexed sequencer for the output (10-neuron) layer of the BNN.
- Streams one neuron's weights at a time, CHUNK bits per cycle, from an external synchronous weight memory.
- Accumulates the XNOR-popcount score for each neuron and keeps a running argmax.
- Presents the winning class on answer together with layer_3_done, under control of the top-level state bus.

Parameters:
- NUM_INPUTS, 196: activation bits per neuron. Must be divisible by CHUNK.
- NUM_NEURONS, 10: output classes. Must be 16 or fewer.
- CHUNK, 28: weight/activation bits processed per cycle.
- ADDR_W, 7: weight-memory address width. Must satisfy 2^ADDR_W >= NUM_NEURONS*NUM_INPUTS/CHUNK.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- state  in  3  top-level phase; this block is active only when state == 3'b100 (s_LAYER_3).
- data_in  in  NUM_INPUTS  flattened layer-2 activations; stable throughout s_LAYER_3.
- w_rd_en  out  1  weight-memory read strobe.
- w_addr  out  ADDR_W  weight word address, equal to n*CHUNKS + c.
- w_data  in  CHUNK  weight word; valid exactly one cycle after the w_rd_en cycle.
- answer  out  4  winning neuron index.
- best_score  out  8  popcount of the winning neuron.
- layer_3_done  out  1  high while answer and best_score are valid.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Definitions:
  - CHUNKS = NUM_INPUTS/CHUNK (7 at defaults).
  - TOTAL = NUM_NEURONS*CHUNKS (70 at defaults).
  - Chunk c of data_in is data_in[c*CHUNK +: CHUNK], so chunk 0 is the LSBs.
  - Word n*CHUNKS+c holds the neuron n weight bits for chunk c.
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - answer, best_score, layer_3_done, busy, w_rd_en and w_addr all go to 0.
  - All counters, the accumulator and the read-valid pipeline register clear.
  - Reset mid-operation discards all progress.
- FSM states:
  - IDLE:
    - On a rising edge with state==s_LAYER_3: go to RUN, clear the neuron counter n, chunk counter c, accumulator and best registers.
    - Otherwise remain in IDLE.
  - RUN:
    - w_rd_en=1 and w_addr=n*CHUNKS+c, driven combinationally from the counters.
    - Each edge advances c; when c wraps from CHUNKS-1 to 0, n increments.
    - The edge that issues address TOTAL-1 moves the FSM to DRAIN.
  - DRAIN:
    - w_rd_en=0; this is the single cycle in which the last word is consumed.
    - Next edge goes to DONE.
  - DONE:
    - layer_3_done=1 (registered).
    - Stay in DONE while state==s_LAYER_3.
    - When state!=s_LAYER_3: go to IDLE, clear layer_3_done. answer and best_score hold their values.
  - Abort: state leaving s_LAYER_3 while in RUN or DRAIN returns the FSM to IDLE on the next edge.
    - layer_3_done is not asserted and the best registers are not updated.
    - Any in-flight read data is ignored.
- Datapath:
  - A one-cycle delayed copy of w_rd_en, n and c (v_d, n_d, c_d) qualifies w_data.
  - On each v_d cycle: s = popcount(~(w_data ^ chunk c_d of data_in)), range 0..CHUNK.
  - If c_d != CHUNKS-1: acc <= acc + s.
  - If c_d == CHUNKS-1:
    - Neuron score = acc + s (8 bits, no overflow for NUM_INPUTS <= 255).
    - acc <= 0.
    - If n_d==0 or score > best_score: best_score <= score and answer <= n_d.
  - Ties keep the lower index.
  - A score of 0 for every neuron still yields answer 0, best_score 0 and layer_3_done asserted.
- Latency:
  - Let E0 be the edge that moves the FSM from IDLE to RUN.
  - Reads are issued in the TOTAL cycles after E0.
  - The FSM enters DONE at edge E0+TOTAL+1, so layer_3_done rises after edge E71 at defaults.
- Re-run: a new pass requires state to leave s_LAYER_3 (FSM back to IDLE) and then re-enter it.

Test Plan:
- Full-match winner:
  - Stimulus: data_in all ones; neuron 3 weights all ones; all other neurons alternate 1010...
  - Required: answer=3, best_score=196, layer_3_done rises exactly 71 edges after E0.
- Address sequence:
  - Stimulus: monitor a full pass.
  - Required: w_rd_en high for exactly 70 consecutive cycles with w_addr 0,1,...,69 in order, then w_rd_en=0.
- Tie-break:
  - Stimulus: neurons 2 and 7 both score 150; all others 100.
  - Required: answer=2, best_score=150.
- All-zero scores:
  - Stimulus: every weight word equals the bitwise inverse of its data chunk.
  - Required: answer=0, best_score=0, layer_3_done=1.
- Abort and restart:
  - Stimulus: drop state to 3'b011 on the 30th RUN cycle.
  - Required: FSM in IDLE next edge, w_rd_en=0, layer_3_done never rises.
  - Stimulus: re-enter s_LAYER_3.
  - Required: addresses restart at 0; correct answer after 71 edges.
- Reset mid-run:
  - Stimulus: assert reset asynchronously between edges at RUN cycle 40.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset with state==s_LAYER_3.
  - Required: a full 70-read pass produces the correct answer.
